// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative divider.
//   div_state_e       : divider FSM state encoding
//   ALU_DIV/ALU_DIVU  : alucontrolE codes the execute stage decodes into
//                       start_i (either code) and signed_i (ALU_DIV only)
package div_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

  localparam int unsigned ALUCTRL_W = 5;
  localparam logic [ALUCTRL_W-1:0] ALU_DIV  = 5'b01100;
  localparam logic [ALUCTRL_W-1:0] ALU_DIVU = 5'b01101;

  function automatic logic is_div_op(input logic [ALUCTRL_W-1:0] alucontrol);
    return (alucontrol == ALU_DIV) || (alucontrol == ALU_DIVU);
  endfunction

  function automatic logic is_signed_div(input logic [ALUCTRL_W-1:0] alucontrol);
    return alucontrol == ALU_DIV;
  endfunction

endpackage

// File: rtl/div_unit.sv
// Multi-cycle restoring radix-2 divider for the execute stage.
//   clk      : clock, rising edge
//   rst      : asynchronous reset, active low
//   start_i  : DIV/DIVU present in E, held while stall_o is high
//   signed_i : 1 = DIV, 0 = DIVU
//   a_i/b_i  : dividend / divisor
//   cancel_i : flush or exception, aborts the operation
//   stall_o  : freeze F/D/E pipeline registers
//   ready_o  : result_o valid this cycle
//   result_o : {remainder, quotient}
// Build option: DIV_ZERO_FASTPATH_EN sends a zero divisor straight to DONE.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic               cancel_i,
  output logic               stall_o,
  output logic               ready_o,
  output logic [2*WIDTH-1:0] result_o
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  div_state_e state, state_next;

  logic [CW-1:0]    count;
  logic [WIDTH-1:0] quo, rem, dvs;
  logic             q_neg, r_neg, dz;

  logic             accept, last_step;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] quo_step, rem_step, quo_final, rem_final;

  // Operand magnitudes and one restoring step on the registered partial
  // remainder; quo doubles as the dividend shift register.
  always_comb begin
    a_neg = signed_i & a_i[WIDTH-1];
    b_neg = signed_i & b_i[WIDTH-1];
    a_mag = a_neg ? -a_i : a_i;
    b_mag = b_neg ? -b_i : b_i;

    trial = {rem, quo[WIDTH-1]} - {1'b0, dvs};
    if (!trial[WIDTH]) begin
      rem_step = trial[WIDTH-1:0];
      quo_step = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_step = {rem[WIDTH-2:0], quo[WIDTH-1]};
      quo_step = {quo[WIDTH-2:0], 1'b0};
    end

    // A zero divisor already yields remainder = |a|; only the quotient
    // needs forcing, since sign correction would otherwise touch it.
    quo_final = dz ? '1 : (q_neg ? -quo_step : quo_step);
    rem_final = r_neg ? -rem_step : rem_step;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    stall_o    = 1'b0;
    ready_o    = 1'b0;
    accept     = 1'b0;
    last_step  = 1'b0;
    case (state)
      ST_IDLE: begin
        stall_o = start_i;
        if (start_i && !cancel_i) begin
          accept = 1'b1;
`ifdef DIV_ZERO_FASTPATH_EN
          state_next = (b_i == '0) ? ST_DONE : ST_BUSY;
`else
          state_next = ST_BUSY;
`endif
        end
      end
      ST_BUSY: begin
        stall_o = 1'b1;
        if (count == LAST) begin
          last_step  = 1'b1;
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        ready_o    = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    if (cancel_i) state_next = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count    <= '0;
      quo      <= '0;
      rem      <= '0;
      dvs      <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      dz       <= 1'b0;
      result_o <= '0;
    end else if (accept) begin
      count <= '0;
      quo   <= a_mag;
      rem   <= '0;
      dvs   <= b_mag;
      q_neg <= a_neg ^ b_neg;
      r_neg <= a_neg;
      dz    <= (b_i == '0);
`ifdef DIV_ZERO_FASTPATH_EN
      if (b_i == '0) result_o <= {a_i, {WIDTH{1'b1}}};
`endif
    end else if (state == ST_BUSY && !cancel_i) begin
      count <= count + CW'(1);
      quo   <= quo_step;
      rem   <= rem_step;
      if (last_step) result_o <= {rem_final, quo_final};
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit (WIDTH = 32). Expected results come from
// a plain-arithmetic reference model; latency expectations follow the
// DIV_ZERO_FASTPATH_EN setting of the build.
module tb_div_unit;

  localparam int unsigned W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           start_i;
  logic           signed_i;
  logic [W-1:0]   a_i;
  logic [W-1:0]   b_i;
  logic           cancel_i;
  logic           stall_o;
  logic           ready_o;
  logic [2*W-1:0] result_o;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;
  int unsigned ready_cyc = 0;
  logic [2*W-1:0] last_result = '0;

  div_unit #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .signed_i (signed_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .cancel_i (cancel_i),
    .stall_o  (stall_o),
    .ready_o  (ready_o),
    .result_o (result_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // {remainder, quotient} from the instruction-set rules.
  function automatic logic [2*W-1:0] ref_div(input bit s, input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [W-1:0] sa, sb, sq, sr;
    if (b == 0) return {a, {W{1'b1}}};
    if (!s) return {a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
    sa = a;
    sb = b;
    sq = sa / sb;
    sr = sa % sb;
    return {sr, sq};
  endfunction

  function automatic int unsigned exp_lat(input logic [W-1:0] b);
`ifdef DIV_ZERO_FASTPATH_EN
    if (b == 0) return 1;
`endif
    return W + 1;
  endfunction

  // Called at a negedge; start accepted in cycle 0. Returns at a negedge.
  task automatic do_div(input string tag, input bit s, input logic [W-1:0] a,
                        input logic [W-1:0] b, input bit keep);
    int unsigned lat;
    logic [2*W-1:0] exp;
    lat = exp_lat(b);
    exp = ref_div(s, a, b);
    signed_i = s;
    a_i      = a;
    b_i      = b;
    start_i  = 1'b1;
    for (int unsigned c = 0; c <= lat; c++) begin
      #1;
      check({tag, "_stall"}, 64'(stall_o), 64'(c < lat));
      check({tag, "_ready"}, 64'(ready_o), 64'(c == lat));
      if (c == lat) begin
        check({tag, "_result"}, result_o, exp);
        ready_cyc = cyc;
      end
      @(negedge clk);
    end
    check({tag, "_hold"}, result_o, exp);
    last_result = exp;
    if (!keep) begin
      start_i = 1'b0;
      #1;
      // A start still high during DONE must not have been taken.
      check({tag, "_idle_after"}, 64'(stall_o), 64'(0));
      @(negedge clk);
    end
  endtask

  initial begin
    int unsigned hits, shits, first_ready;
    logic [W-1:0] ra, rb;
    bit rs;

    rst = 1'b0; start_i = 1'b0; signed_i = 1'b0;
    a_i = '0; b_i = '0; cancel_i = 1'b0;

    // Reset state
    @(negedge clk);
    #1;
    check("rst_ready", 64'(ready_o), 64'(0));
    check("rst_stall", 64'(stall_o), 64'(0));
    check("rst_result", result_o, 64'(0));
    start_i = 1'b1;
    #1;
    check("rst_stall_follows_start", 64'(stall_o), 64'(1));
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Directed cases
    do_div("divu_100_7", 1'b0, 32'd100, 32'd7, 1'b0);
    do_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
    do_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    do_div("divu_5_0", 1'b0, 32'd5, 32'd0, 1'b0);
    do_div("div_m9_0", 1'b1, 32'hFFFF_FFF7, 32'd0, 1'b0);
    do_div("divu_max", 1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0);

    // Back-to-back: second start taken in the IDLE cycle after DONE
    do_div("b2b_9_3", 1'b0, 32'd9, 32'd3, 1'b1);
    first_ready = ready_cyc;
    do_div("b2b_8_2", 1'b0, 32'd8, 32'd2, 1'b0);
    check("b2b_spacing", 64'(ready_cyc - first_ready), 64'(W + 2));

    // Cancel in BUSY cycle 10
    signed_i = 1'b0; a_i = 32'd1000; b_i = 32'd3; start_i = 1'b1;
    for (int i = 0; i < 10; i++) @(negedge clk);
    cancel_i = 1'b1;
    #1;
    check("cancel_busy_stall", 64'(stall_o), 64'(1));
    @(negedge clk);
    cancel_i = 1'b0; start_i = 1'b0;
    #1;
    check("cancel_idle_stall", 64'(stall_o), 64'(0));
    hits = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready_o) hits++;
    end
    check("cancel_no_ready", 64'(hits), 64'(0));
    check("cancel_result_held", result_o, last_result);

    // Cancel wins over a simultaneous start in IDLE
    start_i = 1'b1; cancel_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0; cancel_i = 1'b0;
    hits = 0; shits = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (ready_o) hits++;
      if (stall_o) shits++;
      @(negedge clk);
    end
    check("cancel_start_no_ready", 64'(hits), 64'(0));
    check("cancel_start_no_busy", 64'(shits), 64'(0));
    do_div("after_cancel", 1'b0, 32'd77, 32'd10, 1'b0);

    // Reset in BUSY cycle 5
    signed_i = 1'b1; a_i = 32'd12345; b_i = 32'hFFFF_FFFB; start_i = 1'b1;
    for (int i = 0; i < 5; i++) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_stall", 64'(stall_o), 64'(1));
    check("midrst_ready", 64'(ready_o), 64'(0));
    check("midrst_result", result_o, 64'(0));
    start_i = 1'b0;
    #1;
    check("midrst_stall_idle", 64'(stall_o), 64'(0));
    @(negedge clk);
    rst = 1'b1;
    hits = 0; shits = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (ready_o) hits++;
      if (stall_o) shits++;
      @(negedge clk);
    end
    check("midrst_no_ready", 64'(hits), 64'(0));
    check("midrst_no_busy", 64'(shits), 64'(0));
    do_div("after_rst", 1'b1, 32'hFFFF_FF00, 32'd7, 1'b0);

    // Randomized operands
    for (int i = 0; i < 16; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      do_div("rand", rs, ra, rb, 1'($urandom_range(0, 1)));
    end
    start_i = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
